axis_pkt_gen: RTL
=================

// Module: axis_pkt_gen
// PURPOSE
//  Parametrised AXI4-Stream test-packet generator for the NetFPGA-10G datapath.
//  Emits run-time configurable Ethernet frames on a master stream: length, count,
//  inter-packet gap, MACs, ethertype and TUSER ports, with a per-packet sequence
//  number and a deterministic payload. Holds stream outputs stable under
//  backpressure and keeps packet and byte counters for the register block.
// PARAMETERS
//  C_M_AXIS_DATA_WIDTH   256  TDATA width; multiple of 64; bytes per beat B = width/8
//  C_M_AXIS_TUSER_WIDTH  128  TUSER width; must be >= 32
//  C_LEN_WIDTH           16   width of packet length in bytes
//  C_GAP_WIDTH           16   width of inter-packet gap count
//  C_CNT_WIDTH           32   width of packet-number and statistics counters
// PORTS
//  S_AXI_ACLK     in   1                 clock
//  S_AXI_ARESET   in   1                 synchronous reset, active-high
//  gen_enable     in   1                 level: run generator
//  gen_num_pkts   in   C_CNT_WIDTH       packets per run; 0 = unlimited
//  gen_pkt_len    in   C_LEN_WIDTH       frame length in bytes; values <60 are treated as 60
//  gen_gap        in   C_GAP_WIDTH       idle cycles between packets
//  gen_dst_mac    in   48                destination MAC
//  gen_src_mac    in   48                source MAC
//  gen_ethertype  in   16                ethertype
//  gen_src_port   in   8                 TUSER source-port one-hot
//  gen_dst_port   in   8                 TUSER destination-port one-hot
//  rst_cntrs      in   1                 clear statistics counters
//  M_AXIS_TDATA   out  C_M_AXIS_DATA_WIDTH      stream data; byte 0 in [7:0]
//  M_AXIS_TSTRB   out  C_M_AXIS_DATA_WIDTH/8    byte strobes
//  M_AXIS_TUSER   out  C_M_AXIS_TUSER_WIDTH     metadata, first beat only
//  M_AXIS_TVALID  out  1                        beat valid
//  M_AXIS_TREADY  in   1                        sink ready
//  M_AXIS_TLAST   out  1                        last beat of frame
//  tx_pkt_count   out  C_CNT_WIDTH     frames sent (TLAST handshakes)
//  tx_byte_count  out  C_CNT_WIDTH     bytes sent (sum of effective lengths)
//  gen_busy       out  1               state is not IDLE or DONE
//  gen_done       out  1               run of gen_num_pkts completed
// BEHAVIOUR
//  - All outputs are registered. On reset every output is 0, the FSM is IDLE,
//    and the run and sequence counters are 0.
//  - FSM states: IDLE, SEND, GAP, DONE.
//    - IDLE -> SEND when gen_enable=1. Clear the run counter.
//      First beat has TVALID=1 on the next cycle (latency 1).
//    - SEND: emit beats 0..N-1, with N = ceil(L/B). Advance only on TVALID&TREADY.
//    - On the TLAST handshake: if gen_num_pkts!=0 and run+1==gen_num_pkts -> DONE;
//      else if gen_enable=0 -> IDLE; else if gen_gap=0 -> SEND (back-to-back,
//      next first beat valid the following cycle); else -> GAP.
//    - GAP: TVALID=0 for exactly gen_gap cycles, then SEND. If gen_enable
//      drops during GAP -> IDLE.
//    - DONE: gen_done=1, TVALID=0. Go to IDLE when gen_enable=0.
//  - Sample and hold at each packet start: L = max(gen_pkt_len, 60), MACs,
//    ethertype, ports. Input changes mid-packet have no effect.
//  - Byte at frame offset k = beat*B + lane:
//    - k 0-5: dst MAC, MSB first. k 6-11: src MAC. k 12-13: ethertype, MSB first.
//    - k 14-17: 32-bit sequence number, big-endian, equal to the packet index in
//      the run (wraps mod 2^32).
//    - k >= 18: k[7:0].
//    - k >= L: 0x00.
//  - TSTRB: all ones except on the last beat, which is ones in the low (L mod B)
//    lanes, or all ones when L mod B = 0.
//  - TUSER on beat 0 = {0, gen_dst_port, gen_src_port, L[15:0]} at bits
//    [31:24], [23:16] and [15:0]; 0 on other beats.
//  - AXIS rule: while TVALID=1 and TREADY=0, TDATA/TSTRB/TUSER/TLAST hold
//    stable. TVALID never drops before its handshake, except on reset.
//    Packets are never truncated: dropping gen_enable ends the run after the
//    current frame.
//  - Counters: on a TLAST handshake, tx_pkt_count += 1 and tx_byte_count += L;
//    both wrap mod 2^C_CNT_WIDTH. rst_cntrs clears both and wins over a
//    same-cycle increment. rst_cntrs does not affect the FSM.
//  - Reset mid-packet: TVALID=0 on the next cycle. The frame is abandoned and
//    counters are cleared.
// TESTING
//  1 W=256, L=64, num=1, gap=0, TREADY=1, src=0x80, dst=0x04.
//    -> 2 beats; beat0 TUSER=0x04800040; beat1 TLAST=1, TSTRB=0xFFFFFFFF.
//    -> tx_pkt_count=1, tx_byte_count=64, gen_done=1.
//  2 L=65 -> 3 beats; last TSTRB=0x00000001, last byte=0x40; L=20 -> sent as
//    60 bytes, TUSER[15:0]=60.
//  3 Random TREADY (50%), L=150, num=4 -> stream identical to the TREADY=1
//    run; no output changes while a beat is stalled.
//  4 num=3, gap=5 -> exactly 5 idle cycles between frames; bytes 14-17
//    carry 0, 1, 2; gen_done after frame 3.
//  5 gen_enable dropped on beat 1 of a 4-beat frame -> frame completes, then
//    IDLE; S_AXI_ARESET on beat 2 -> TVALID=0 next cycle, counters=0.
//  6 rst_cntrs in the same cycle as a TLAST handshake -> tx_pkt_count=0;
//    counter preset near 2^32-1 wraps to 0.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream test-packet generator.
// Emits Ethernet-style frames made of a MAC/ethertype header, a 32-bit
// sequence number and a counting payload. Frame length, packet count,
// inter-packet gap and TUSER ports are set at run time. Outputs are held
// stable under backpressure. Packet and byte statistics feed the register block.
`timescale 1ns/1ps

module axis_pkt_gen #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_LEN_WIDTH          = 16,
    parameter int C_GAP_WIDTH          = 16,
    parameter int C_CNT_WIDTH          = 32
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic                              gen_enable,
    input  logic [C_CNT_WIDTH-1:0]            gen_num_pkts,
    input  logic [C_LEN_WIDTH-1:0]            gen_pkt_len,
    input  logic [C_GAP_WIDTH-1:0]            gen_gap,
    input  logic [47:0]                       gen_dst_mac,
    input  logic [47:0]                       gen_src_mac,
    input  logic [15:0]                       gen_ethertype,
    input  logic [7:0]                        gen_src_port,
    input  logic [7:0]                        gen_dst_port,
    input  logic                              rst_cntrs,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,
    output logic [C_CNT_WIDTH-1:0]            tx_pkt_count,
    output logic [C_CNT_WIDTH-1:0]            tx_byte_count,
    output logic                              gen_busy,
    output logic                              gen_done
);

    localparam int DW    = C_M_AXIS_DATA_WIDTH;
    localparam int UW    = C_M_AXIS_TUSER_WIDTH;
    localparam int LW    = C_LEN_WIDTH;
    localparam int GW    = C_GAP_WIDTH;
    localparam int CW    = C_CNT_WIDTH;
    localparam int BYTES = DW / 8;

    localparam logic [LW-1:0] MIN_LEN = LW'(60);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Beat builders: pure functions of (length, beat index, header fields)
    // ------------------------------------------------------------------

    // Data bytes of one beat; header for offsets 0..17, k[7:0] afterwards,
    // zero beyond the frame end.
    function automatic logic [DW-1:0] beat_data(
        input logic [31:0] len,
        input logic [31:0] beat,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] etype,
        input logic [31:0] seq
    );
        logic [DW-1:0]  data;
        logic [143:0]   hdr;
        logic [31:0]    k;
        logic [7:0]     byte_v;
        data = '0;
        hdr  = {dst, src, etype, seq};
        for (int lane = 0; lane < BYTES; lane++) begin
            k = beat * 32'(BYTES) + 32'(lane);
            if (k < len) begin
                if (k < 32'd18) begin
                    byte_v = 8'(hdr >> (8 * (32'd17 - k)));
                end else begin
                    byte_v = k[7:0];
                end
                data[lane*8 +: 8] = byte_v;
            end
        end
        return data;
    endfunction

    // Lane strobes: set for every byte offset still inside the frame.
    function automatic logic [BYTES-1:0] beat_strb(
        input logic [31:0] len,
        input logic [31:0] beat
    );
        logic [BYTES-1:0] strb;
        for (int lane = 0; lane < BYTES; lane++) begin
            strb[lane] = (beat * 32'(BYTES) + 32'(lane)) < len;
        end
        return strb;
    endfunction

    // ------------------------------------------------------------------
    // State and held per-packet configuration
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [LW-1:0]   len_q;
    logic [47:0]     dst_q, src_q;
    logic [15:0]     etype_q;
    logic [7:0]      sport_q, dport_q;
    logic [LW-1:0]   beat_q;
    logic [31:0]     seq_q;
    logic [CW-1:0]   run_q;
    logic [GW-1:0]   gap_q;

    // Control strobes from the next-state logic
    logic            hs;
    logic            start_pkt;
    logic            next_beat;
    logic            run_clr;
    logic            run_inc;
    logic            gap_load;
    logic [31:0]     start_seq;

    // Builder inputs and results
    logic [LW-1:0]   eff_len_in;
    logic [31:0]     sel_len;
    logic [31:0]     sel_beat;
    logic [DW-1:0]   bld_data;
    logic [BYTES-1:0] bld_strb;
    logic            bld_last;
    logic [UW-1:0]   bld_user;

    assign hs         = M_AXIS_TVALID & M_AXIS_TREADY;
    assign eff_len_in = (gen_pkt_len < MIN_LEN) ? MIN_LEN : gen_pkt_len;

    // Next-state and control decode for the generator FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        start_pkt = 1'b0;
        next_beat = 1'b0;
        run_clr   = 1'b0;
        run_inc   = 1'b0;
        gap_load  = 1'b0;
        start_seq = seq_q + 32'd1;
        case (state_q)
            ST_IDLE: begin
                if (gen_enable) begin
                    state_d   = ST_SEND;
                    start_pkt = 1'b1;
                    run_clr   = 1'b1;
                    start_seq = 32'd0;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if (M_AXIS_TLAST) begin
                        run_inc = 1'b1;
                        if ((gen_num_pkts != '0) && (run_q + CW'(1) == gen_num_pkts)) begin
                            state_d = ST_DONE;
                        end else if (!gen_enable) begin
                            state_d = ST_IDLE;
                        end else if (gen_gap == '0) begin
                            state_d   = ST_SEND;
                            start_pkt = 1'b1;
                        end else begin
                            state_d  = ST_GAP;
                            gap_load = 1'b1;
                        end
                    end else begin
                        next_beat = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!gen_enable) begin
                    state_d = ST_IDLE;
                end else if (gap_q == '0) begin
                    state_d   = ST_SEND;
                    start_pkt = 1'b1;
                end
            end
            ST_DONE: begin
                if (!gen_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pick live inputs for a new packet or held values for the next beat.
    always_comb begin
        sel_len  = start_pkt ? 32'(eff_len_in) : 32'(len_q);
        sel_beat = start_pkt ? 32'd0 : (32'(beat_q) + 32'd1);
        bld_data = start_pkt
                 ? beat_data(sel_len, sel_beat, gen_dst_mac, gen_src_mac, gen_ethertype, start_seq)
                 : beat_data(sel_len, sel_beat, dst_q, src_q, etype_q, seq_q);
        bld_strb = beat_strb(sel_len, sel_beat);
        bld_last = ((sel_beat + 32'd1) * 32'(BYTES)) >= sel_len;
        bld_user = start_pkt ? UW'({gen_dst_port, gen_src_port, 16'(sel_len)}) : '0;
    end

    // FSM state register.
    always_ff @(posedge S_AXI_ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (S_AXI_ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample and hold the frame configuration at each packet start.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            len_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            etype_q <= '0;
            sport_q <= '0;
            dport_q <= '0;
            seq_q   <= '0;
            beat_q  <= '0;
        end else if (start_pkt) begin
            len_q   <= eff_len_in;
            dst_q   <= gen_dst_mac;
            src_q   <= gen_src_mac;
            etype_q <= gen_ethertype;
            sport_q <= gen_src_port;
            dport_q <= gen_dst_port;
            seq_q   <= start_seq;
            beat_q  <= '0;
        end else if (next_beat) begin
            beat_q  <= beat_q + LW'(1);
        end
    end

    // Stream output registers: load a new beat, clear after the last handshake, otherwise hold.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (start_pkt || next_beat) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= bld_data;
            M_AXIS_TSTRB  <= bld_strb;
            M_AXIS_TUSER  <= bld_user;
            M_AXIS_TLAST  <= bld_last;
        end else if (hs) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end
    end

    // Inter-packet gap down-counter; loaded with gap-1 so GAP lasts exactly gen_gap cycles.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            gap_q <= '0;
        end else if (gap_load) begin
            gap_q <= gen_gap - GW'(1);
        end else if ((state_q == ST_GAP) && (gap_q != '0)) begin
            gap_q <= gap_q - GW'(1);
        end
    end

    // Frames completed in the current run.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || run_clr) begin
            run_q <= '0;
        end else if (run_inc) begin
            run_q <= run_q + CW'(1);
        end
    end

    // Statistics counters; rst_cntrs beats a same-cycle increment.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || rst_cntrs) begin
            tx_pkt_count  <= '0;
            tx_byte_count <= '0;
        end else if (hs && M_AXIS_TLAST) begin
            tx_pkt_count  <= tx_pkt_count + CW'(1);
            tx_byte_count <= tx_byte_count + CW'(len_q);
        end
    end

    // Registered status flags decoded from the next state.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            gen_busy <= 1'b0;
            gen_done <= 1'b0;
        end else begin
            gen_busy <= (state_d == ST_SEND) || (state_d == ST_GAP);
            gen_done <= (state_d == ST_DONE);
        end
    end

    // Held ports are kept for observability of the current packet.
    logic unused_ports;
    assign unused_ports = ^{sport_q, dport_q};

endmodule
